// File: rtl/byte_bank_reader.sv
// Small register bank with a registered read port that presents either one
// entry or all entries in address order through a valid/ready output stream.
module byte_bank_reader #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_sel,
  input  logic              scan,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] next_addr;
  logic              handshake;

  // Output stream: a beat transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low the
  // beat (out_valid, out_data, out_addr) is held unchanged.
  assign handshake = out_valid && out_ready;
  assign next_addr = out_addr + ADDR_W'(1);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Reads below sample mem before this write lands, so a same-edge
      // collision returns the old value.
      if (wr_en) begin
        mem[wr_sel] <= wr_data;
      end
      case (state)
        IDLE: begin
          if (rd_req) begin
            out_valid <= 1'b1;
            if (scan) begin
              state    <= SCAN;
              out_data <= mem[0];
              out_addr <= '0;
            end else begin
              state    <= SINGLE;
              out_data <= mem[rd_sel];
              out_addr <= rd_sel;
            end
          end
        end
        SINGLE: begin
          if (handshake) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        SCAN: begin
          if (handshake) begin
            if (out_addr == LAST_ADDR) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              out_data <= mem[next_addr];
              out_addr <= next_addr;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_bank_reader.sv
// Bench for byte_bank_reader: vector table, directed corner sequences and a
// randomized run, all compared against a transaction-level reference model.
module tb_byte_bank_reader;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_sel = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_sel = '0;
  logic              scan = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  byte_bank_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_req(rd_req), .rd_sel(rd_sel), .scan(scan),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: bank contents, the beat on display, and the queue of
  // addresses still to be presented in the current operation
  logic [WIDTH-1:0]  m_mem [DEPTH];
  logic              m_valid;
  logic [WIDTH-1:0]  m_data;
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] exp_q [$];

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_addr  = '0;
    exp_q   = {};
  endfunction

  function automatic void model_step(input logic we, input logic [ADDR_W-1:0] ws,
                                     input logic [WIDTH-1:0] wd, input logic rq,
                                     input logic sc, input logic [ADDR_W-1:0] rs,
                                     input logic rdy);
    logic [WIDTH-1:0] old [DEPTH];
    old = m_mem;
    if (!m_valid) begin
      if (rq) begin
        exp_q = {};
        if (sc) begin
          for (int i = 1; i < DEPTH; i++) exp_q.push_back(ADDR_W'(i));
          m_addr = '0;
        end else begin
          m_addr = rs;
        end
        m_data  = old[m_addr];
        m_valid = 1'b1;
      end
    end else if (rdy) begin
      if (exp_q.size() > 0) begin
        m_addr = exp_q.pop_front();
        m_data = old[m_addr];
      end else begin
        m_valid = 1'b0;
      end
    end
    if (we) m_mem[ws] = wd;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_valid", 32'(out_valid), 32'(m_valid));
    check("model_busy", 32'(busy), 32'(m_valid));
    if (m_valid) begin
      check("model_data", 32'(out_data), 32'(m_data));
      check("model_addr", 32'(out_addr), 32'(m_addr));
    end
  endtask

  // driver: apply one cycle of inputs, advance model, compare after the edge
  task automatic drive(input logic we, input logic [ADDR_W-1:0] ws, input logic [WIDTH-1:0] wd,
                       input logic rq, input logic sc, input logic [ADDR_W-1:0] rs,
                       input logic rdy);
    wr_en = we; wr_sel = ws; wr_data = wd;
    rd_req = rq; scan = sc; rd_sel = rs; out_ready = rdy;
    model_step(we, ws, wd, rq, sc, rs, rdy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, rdy);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    drive(1'b1, a, d, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic expect_beat(input string name, input logic [WIDTH-1:0] d, input logic [ADDR_W-1:0] a);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(d));
    check({name, "_addr"}, 32'(out_addr), 32'(a));
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] ws;
    logic [WIDTH-1:0]  wd;
    logic              rq;
    logic              sc;
    logic [ADDR_W-1:0] rs;
    logic              rdy;
    logic              ev;
    logic [WIDTH-1:0]  ed;
    logic [ADDR_W-1:0] ea;
    logic              eb;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // reset-then-read and held single read
    vecs[0] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1};
    vecs[1] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 8'hA5, 2'd2, 1'b1};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'hA5, 2'd2, 1'b1};
    vecs[5] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'hA5, 2'd2, 1'b1};
    vecs[6] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0};

    model_reset();
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].we, vecs[i].ws, vecs[i].wd, vecs[i].rq, vecs[i].sc, vecs[i].rs, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
        check($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(vecs[i].ea));
      end
    end

    // full scan with ready held high
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
    idle(1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 2'd2, 1'b1);
    expect_beat("scan0", 8'h11, 2'd0);
    idle(1'b1); expect_beat("scan1", 8'h22, 2'd1);
    idle(1'b1); expect_beat("scan2", 8'h33, 2'd2);
    idle(1'b1); expect_beat("scan3", 8'h44, 2'd3);
    idle(1'b1);
    check("scan_end_valid", 32'(out_valid), 32'd0);
    check("scan_end_busy", 32'(busy), 32'd0);

    // scan with backpressure and writes landing mid-scan
    drive(1'b0, '0, '0, 1'b1, 1'b1, 2'd0, 1'b0);
    expect_beat("bp0", 8'h11, 2'd0);
    idle(1'b1); expect_beat("bp1", 8'h22, 2'd1);
    drive(1'b1, 2'd3, 8'h99, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_beat("bp1_hold", 8'h22, 2'd1);
    drive(1'b1, 2'd1, 8'h77, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_beat("bp1_wr_presented", 8'h22, 2'd1);
    idle(1'b1); expect_beat("bp2", 8'h33, 2'd2);
    idle(1'b0); expect_beat("bp2_hold", 8'h33, 2'd2);
    idle(1'b1); expect_beat("bp3", 8'h99, 2'd3);
    idle(1'b0); expect_beat("bp3_hold", 8'h99, 2'd3);
    idle(1'b1);
    check("bp_end_valid", 32'(out_valid), 32'd0);

    // same-edge write/read collision, then rd_req while busy
    drive(1'b1, 2'd1, 8'h5A, 1'b1, 1'b0, 2'd1, 1'b0);
    expect_beat("coll", 8'h77, 2'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 2'd0, 1'b0);
    expect_beat("busy_req", 8'h77, 2'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 2'd0, 1'b1);
    check("busy_req_end", 32'(out_valid), 32'd0);
    idle(1'b0);
    check("busy_req_idle", 32'(out_valid), 32'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 2'd1, 1'b0);
    expect_beat("coll_new", 8'h5A, 2'd1);
    idle(1'b1);

    // asynchronous reset in the middle of a scan
    drive(1'b0, '0, '0, 1'b1, 1'b1, 2'd0, 1'b1);
    idle(1'b1); idle(1'b1);
    expect_beat("pre_rst", 8'h33, 2'd2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, ADDR_W'(a), 1'b0);
      expect_beat($sformatf("post_rst_e%0d", a), 8'h00, ADDR_W'(a));
      idle(1'b1);
      idle(1'b0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
            WIDTH'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 3) != 0));
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_bank_reader.md
BYTE_BANK_READER -- requirements
Module: byte_bank_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of each stored entry.
REQ-002 SHALL have parameter ADDR_W, default 2, meaning the address width; depth = 2**ADDR_W entries (4 by default).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  write strobe for the entry selected by wr_sel.
REQ-006 SHALL have port wr_sel  input  ADDR_W  write address.
REQ-007 SHALL have port wr_data  input  WIDTH  write data.
REQ-008 SHALL have port rd_req  input  1  read request; sampled only when idle.
REQ-009 SHALL have port rd_sel  input  ADDR_W  single-read address.
REQ-010 SHALL have port scan  input  1  qualifies rd_req: 1 = read all entries in order 0..max; 0 = single read.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 SHALL have port out_valid  output  1  out_data/out_addr hold a valid entry.
REQ-013 SHALL have port out_data  output  WIDTH  registered read data.
REQ-014 SHALL have port out_addr  output  ADDR_W  address of the entry on out_data.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL store 2**ADDR_W entries of WIDTH bits; wr_en=1 writes wr_data to entry wr_sel at the rising edge, in every state.
REQ-017 SHALL implement FSM states IDLE, SINGLE and SCAN; busy = (state != IDLE).
REQ-018 In IDLE, rd_req=1 SHALL be accepted; rd_req SHALL be ignored in SINGLE and SCAN.
REQ-019 On acceptance with scan=0, SHALL go to SINGLE and load out_data=mem[rd_sel], out_addr=rd_sel, out_valid=1 at that edge (latency 1 cycle).
REQ-020 On acceptance with scan=1, SHALL go to SCAN and load out_data=mem[0], out_addr=0, out_valid=1 at that edge; rd_sel is ignored.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_addr and out_valid SHALL hold unchanged.
REQ-022 Handshake = out_valid and out_ready both high at a rising edge.
REQ-023 In SINGLE, a handshake SHALL clear out_valid and return to IDLE at that edge.
REQ-024 In SCAN, a handshake with out_addr < max SHALL load mem[out_addr+1] and out_addr+1 with out_valid kept at 1 (back-to-back, no bubble).
REQ-025 In SCAN, a handshake with out_addr = max SHALL clear out_valid and return to IDLE; out_addr SHALL NOT wrap to 0 while valid.
REQ-026 A new rd_req SHALL be accepted no earlier than the cycle after return to IDLE (one idle cycle minimum between operations).
REQ-027 A write and a read load of the same entry at the same edge SHALL load the old (pre-write) value.
REQ-028 A write to the entry currently presented SHALL NOT change out_data; a write to a not-yet-presented entry during SCAN SHALL be visible when that entry is loaded.
REQ-029 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock edge, force state=IDLE, out_valid=0, out_data=0, out_addr=0, busy=0, and all stored entries=0.
REQ-031 Reset asserted mid-SINGLE or mid-SCAN SHALL abort the operation; no further entries SHALL be presented after release.
REQ-032 After rst_n deasserts, the first rising edge SHALL operate normally (writes and rd_req accepted).

Verification
REQ-033 Reset then read: assert rst_n=0, release, rd_req=1 scan=0 rd_sel=3 -> next cycle out_valid=1, out_data=0x00, out_addr=3, busy=1.
REQ-034 Write/single read: write 0xA5 to 2, then rd_req scan=0 rd_sel=2 with out_ready=0 for 3 cycles -> out_data=0xA5 held stable; out_ready=1 -> out_valid=0, busy=0 next cycle.
REQ-035 Full scan: entries {0x11,0x22,0x33,0x44}, rd_req scan=1, out_ready=1 held -> out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles with out_addr 0..3, then out_valid=0.
REQ-036 Scan with backpressure and writes: out_ready toggling 1/0; write 0x99 to entry 3 while entry 1 is presented -> sequence 0x11,0x22,0x33,0x99; write to entry 1 while presented leaves out_data=0x22.
REQ-037 Collision/ignore: write 0x5A to 1 at the same edge rd_req scan=0 rd_sel=1 is accepted -> out_data = old value; rd_req pulsed while busy -> no effect on sequence.
REQ-038 Reset mid-scan: assert rst_n=0 while out_addr=2 -> out_valid=0, busy=0, out_data=0 immediately; entries read back 0x00 afterward.
